// File: rtl/jtag_tap_oversampled_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_tap_oversampled_if : DMI request/response bundle               |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface jtag_tap_oversampled_if;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_data, req_op,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op,
        output req_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_oversampled.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_tap_oversampled : clk-domain 1149.1 TAP with IDCODE/BYPASS/DMI |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module jtag_tap_oversampled #(
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
    parameter logic [4:0]  IR_IDCODE   = 5'h01,
    parameter logic [4:0]  IR_DMI      = 5'h11,
    parameter int          SYNC_STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        jtag_tck_i,
    input  wire logic        jtag_tms_i,
    input  wire logic        jtag_tdi_i,
    output logic             jtag_tdo_o,
    output logic             jtag_tdo_oe_o,
    output logic [3:0]       tap_state_o,
    jtag_tap_oversampled_if.master dmi
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [1:0] SEL_BYP = 2'd0;
    localparam logic [1:0] SEL_ID  = 2'd1;
    localparam logic [1:0] SEL_DMI = 2'd2;

    logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
    logic                   tck_hist_q;
    tap_state_e             state_q, state_d;
    logic                   tdo_oe_q, tdo_q;
    logic [4:0]             ir_q, ir_sr_q;
    logic [31:0]            id_sr_q;
    logic                   byp_q;
    logic [40:0]            dmi_sr_q;
    logic                   req_valid_q, pending_q, sticky_q;
    logic [6:0]             req_addr_q;
    logic [31:0]            req_data_q, rsp_q;
    logic [1:0]             req_op_q;

    logic w_tck, w_tms, w_tdi, w_tck_rise, w_tck_fall;
    logic w_upd_ir, w_upd_dr, w_busy, w_dr_lsb;
    logic [1:0] w_dr_sel;

    assign w_tck      = tck_sync_q[SYNC_STAGES-1];
    assign w_tms      = tms_sync_q[SYNC_STAGES-1];
    assign w_tdi      = tdi_sync_q[SYNC_STAGES-1];
    assign w_tck_rise = w_tck & ~tck_hist_q;
    assign w_tck_fall = ~w_tck & tck_hist_q;
    assign w_upd_ir   = w_tck_rise && (state_d == UPD_IR);
    assign w_upd_dr   = w_tck_rise && (state_d == UPD_DR);
    // A response landing in the same clk as Update-DR frees the slot.
    assign w_busy     = (pending_q && !dmi.rsp_valid) || sticky_q;

    always_comb begin
        w_dr_sel = SEL_BYP;
        if (ir_q == IR_IDCODE)   w_dr_sel = SEL_ID;
        else if (ir_q == IR_DMI) w_dr_sel = SEL_DMI;
        case (w_dr_sel)
            SEL_ID:  w_dr_lsb = id_sr_q[0];
            SEL_DMI: w_dr_lsb = dmi_sr_q[0];
            default: w_dr_lsb = byp_q;
        endcase
    end

    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:     state_d = w_tms ? TLR    : RTI;
            RTI:     state_d = w_tms ? SEL_DR : RTI;
            SEL_DR:  state_d = w_tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = w_tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = w_tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = w_tms ? UPD_DR : PA_DR;
            PA_DR:   state_d = w_tms ? EX2_DR : PA_DR;
            EX2_DR:  state_d = w_tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = w_tms ? SEL_DR : RTI;
            SEL_IR:  state_d = w_tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = w_tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = w_tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = w_tms ? UPD_IR : PA_IR;
            PA_IR:   state_d = w_tms ? EX2_IR : PA_IR;
            EX2_IR:  state_d = w_tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = w_tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_hist_q <= 1'b0;
            state_q    <= TLR;
            tdo_oe_q   <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], jtag_tck_i};
            tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], jtag_tms_i};
            tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], jtag_tdi_i};
            tck_hist_q <= w_tck;
            if (w_tck_rise) begin
                state_q  <= state_d;
                tdo_oe_q <= (state_d == SH_DR) || (state_d == SH_IR);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= 5'b00001;
            id_sr_q     <= '0;
            byp_q       <= 1'b0;
            dmi_sr_q    <= '0;
            tdo_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
            rsp_q       <= '0;
            pending_q   <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            // Capture repeats every clk while parked in Capture; harmless since no shift occurs there.
            if (state_q == CAP_IR) ir_sr_q <= 5'b00001;
            if (state_q == CAP_DR) begin
                id_sr_q  <= IDCODE_VAL;
                byp_q    <= 1'b0;
                dmi_sr_q <= {req_addr_q, rsp_q, sticky_q ? 2'b11 : 2'b00};
            end
            if (w_tck_rise && state_q == SH_IR) ir_sr_q <= {w_tdi, ir_sr_q[4:1]};
            if (w_tck_rise && state_q == SH_DR) begin
                case (w_dr_sel)
                    SEL_ID:  id_sr_q  <= {w_tdi, id_sr_q[31:1]};
                    SEL_DMI: dmi_sr_q <= {w_tdi, dmi_sr_q[40:1]};
                    default: byp_q    <= w_tdi;
                endcase
            end
            if (w_tck_fall && state_q == SH_IR) tdo_q <= ir_sr_q[0];
            if (w_tck_fall && state_q == SH_DR) tdo_q <= w_dr_lsb;

            if (state_q == TLR) begin
                ir_q     <= IR_IDCODE;
                sticky_q <= 1'b0;
            end else if (w_upd_ir) begin
                ir_q <= ir_sr_q;
            end

            if (req_valid_q && dmi.req_ready) req_valid_q <= 1'b0;
            if (dmi.rsp_valid && pending_q) begin
                rsp_q     <= dmi.rsp_data;
                pending_q <= 1'b0;
            end
            if (w_upd_dr && ir_q == IR_DMI) begin
                case (dmi_sr_q[1:0])
                    2'd1, 2'd2: begin
                        if (!w_busy) begin
                            req_addr_q  <= dmi_sr_q[40:34];
                            req_data_q  <= dmi_sr_q[33:2];
                            req_op_q    <= dmi_sr_q[1:0];
                            req_valid_q <= 1'b1;
                            pending_q   <= 1'b1;
                        end else begin
                            sticky_q <= 1'b1;
                        end
                    end
                    2'd3:    sticky_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign jtag_tdo_o    = tdo_q;
    assign jtag_tdo_oe_o = tdo_oe_q;
    assign tap_state_o   = state_q;
    assign dmi.req_valid = req_valid_q;
    assign dmi.req_addr  = req_addr_q;
    assign dmi.req_data  = req_data_q;
    assign dmi.req_op    = req_op_q;

endmodule
`default_nettype wire
